// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// ---------------
// This is a single-clock FIFO with a configurable width and depth. It has
// registered status flags, an occupancy count, and one-cycle overflow and
// underflow error pulses. Two read styles are available:
//   FWFT = 0 : Standard read. Data appears on data_out one cycle after the read edge.
//   FWFT = 1 : First-word-fall-through. data_out always shows the head entry
//              whenever the FIFO is not empty.
//
// Ports
//   clk          in   rising-edge clock for all logic
//   rst          in   synchronous active-high reset
//   we           in   write request
//   re           in   read request
//   data_in      in   [DATA_WIDTH]   write data
//   data_out     out  [DATA_WIDTH]   read data (registered)
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  [$clog2(DEPTH)+1]  occupancy, 0..DEPTH
//   overflow     out  one-cycle pulse after a rejected write
//   underflow    out  one-cycle pulse after a rejected read
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    re,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_COUNT   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_next;
    logic [PW-1:0]         rd_ptr_next;
    logic [CW-1:0]         count_next;
    logic                  rd_ok;
    logic                  wr_ok;

    // Accept logic. A write into a full FIFO is allowed only when a read
    // frees a slot on the same edge. Because empty blocks rd_ok, a combined
    // read and write on an empty FIFO turns into a write only.
    always_comb begin
        rd_ok       = re && !empty;
        wr_ok       = we && (!full || rd_ok);
        wr_ptr_next = wr_ok ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_next = rd_ok ? rd_ptr + PW'(1) : rd_ptr;
        count_next  = count;
        if (wr_ok && !rd_ok)
            count_next = count + CW'(1);
        else if (rd_ok && !wr_ok)
            count_next = count - CW'(1);
    end

    // The storage array is deliberately left without a reset. Old contents
    // are never visible after a reset, because the pointers and count restart.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_ptr] <= data_in;
    end

    // Pointers, count and flags. The flags are derived from count_next, so
    // they agree with the new count right after each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= (count_next == FULL_COUNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_COUNT);
            almost_empty <= (count_next <= AE_COUNT);
            overflow     <= we && !wr_ok;
            underflow    <= re && !rd_ok;
        end
    end

    // Read data register.
    // In FWFT mode, this register is loaded with the entry that will be at
    // the head after the edge. When that head is the word being written on
    // this same edge, the word does not exist in mem yet. It is therefore
    // taken from data_in into the register. It first shows on data_out in
    // the following cycle, never combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (FWFT == 0) begin
            if (rd_ok)
                data_out <= mem[rd_ptr];
        end else if (count_next != '0) begin
            if (wr_ok && (rd_ptr_next == wr_ptr))
                data_out <= data_in;
            else
                data_out <= mem[rd_ptr_next];
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// ------------------
// This bench drives the same stimulus into two default-sized FIFOs: one in
// standard read mode and one in FWFT mode. It keeps a queue-based reference
// model of the expected contents and read data.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout0, dout1;
    logic [CW-1:0] cnt0, cnt1;
    logic full0, empty0, af0, ae0, ovf0, udf0;
    logic full1, empty1, af1, ae1, ovf1, udf1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d0  = '0;
    logic [DW-1:0] exp_d1  = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_udf = 1'b0;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .we(we), .re(re), .data_in(data_in),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .we(we), .re(re), .data_in(data_in),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    always #5 clk = ~clk;

    // Drive one clock edge and advance the reference model.
    // Outputs are sampled 1 ns after the edge.
    task automatic do_edge(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        logic rd_ok, wr_ok;
        we = w; re = r; data_in = d; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            exp_d0 = '0; exp_d1 = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
        end else begin
            rd_ok   = r && (q.size() != 0);
            wr_ok   = w && ((q.size() != DEPTH) || rd_ok);
            exp_ovf = w && !wr_ok;
            exp_udf = r && !rd_ok;
            if (rd_ok) begin
                exp_d0 = q.pop_front();
                exp_d1 = exp_d0;
            end
            if (wr_ok) q.push_back(d);
            if (q.size() != 0) exp_d1 = q[0];
        end
        #1;
        we = 1'b0; re = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        do_edge(1'b1, 1'b1, 8'hFF, 1'b1);
        do_edge(1'b1, 1'b1, 8'hFF, 1'b1);
        we = 1'b0; re = 1'b0;
        n_checks++; if (cnt0 !== 5'd0) begin n_fail++; $display("[TB] FAIL reset count: got %0d expected 0", cnt0); end
        n_checks++; if ({full0, empty0, af0, ae0, ovf0, udf0} !== 6'b010100) begin n_fail++; $display("[TB] FAIL reset flags: got %b expected 010100", {full0, empty0, af0, ae0, ovf0, udf0}); end
        n_checks++; if (dout0 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset data_out std: got %0h expected 0", dout0); end
        n_checks++; if ({full1, empty1, af1, ae1, ovf1, udf1} !== 6'b010100) begin n_fail++; $display("[TB] FAIL reset flags fwft: got %b expected 010100", {full1, empty1, af1, ae1, ovf1, udf1}); end
        n_checks++; if (dout1 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset data_out fwft: got %0h expected 0", dout1); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            do_edge(1'b1, 1'b0, 8'(i), 1'b0);
            n_checks++; if (cnt0 !== CW'(i)) begin n_fail++; $display("[TB] FAIL fill count %0d: got %0d expected %0d", i, cnt0, i); end
            n_checks++; if (af0 !== (i >= 14)) begin n_fail++; $display("[TB] FAIL fill almost_full %0d: got %b expected %b", i, af0, (i >= 14)); end
            n_checks++; if (full0 !== (i == DEPTH)) begin n_fail++; $display("[TB] FAIL fill full %0d: got %b expected %b", i, full0, (i == DEPTH)); end
            n_checks++; if (ae0 !== (i <= 2)) begin n_fail++; $display("[TB] FAIL fill almost_empty %0d: got %b expected %b", i, ae0, (i <= 2)); end
            n_checks++; if (dout1 !== 8'h01) begin n_fail++; $display("[TB] FAIL fill fwft head %0d: got %0h expected 1", i, dout1); end
        end
        do_edge(1'b1, 1'b0, 8'd17, 1'b0);
        n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("[TB] FAIL overflow pulse: got %b expected 1", ovf0); end
        n_checks++; if (cnt0 !== 5'd16) begin n_fail++; $display("[TB] FAIL overflow count: got %0d expected 16", cnt0); end
        do_edge(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("[TB] FAIL overflow width: got %b expected 0", ovf0); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            do_edge(1'b0, 1'b1, 8'd0, 1'b0);
            n_checks++; if (dout0 !== 8'(i)) begin n_fail++; $display("[TB] FAIL drain data %0d: got %0d expected %0d", i, dout0, i); end
            n_checks++; if (cnt0 !== CW'(DEPTH - i)) begin n_fail++; $display("[TB] FAIL drain count %0d: got %0d expected %0d", i, cnt0, DEPTH - i); end
            n_checks++; if (empty0 !== (i == DEPTH)) begin n_fail++; $display("[TB] FAIL drain empty %0d: got %b expected %b", i, empty0, (i == DEPTH)); end
            n_checks++; if (dout1 !== exp_d1) begin n_fail++; $display("[TB] FAIL drain fwft data %0d: got %0h expected %0h", i, dout1, exp_d1); end
        end
        do_edge(1'b0, 1'b1, 8'd0, 1'b0);
        n_checks++; if (udf0 !== 1'b1) begin n_fail++; $display("[TB] FAIL underflow pulse: got %b expected 1", udf0); end
        n_checks++; if (dout0 !== 8'd16) begin n_fail++; $display("[TB] FAIL underflow hold: got %0d expected 16", dout0); end
        do_edge(1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (udf0 !== 1'b0) begin n_fail++; $display("[TB] FAIL underflow width: got %b expected 0", udf0); end
    endtask

    task automatic test_simul_full();
        logic [DW-1:0] pre[DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            pre[i] = 8'($urandom);
            do_edge(1'b1, 1'b0, pre[i], 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            do_edge(1'b1, 1'b1, 8'(101 + i), 1'b0);
            n_checks++; if (cnt0 !== 5'd16 || ovf0 !== 1'b0) begin n_fail++; $display("[TB] FAIL simul count/ovf %0d: got %0d/%b expected 16/0", i, cnt0, ovf0); end
            n_checks++; if (dout0 !== ((i < DEPTH) ? pre[i] : 8'(85 + i))) begin n_fail++; $display("[TB] FAIL simul data %0d: got %0d expected %0d", i, dout0, (i < DEPTH) ? pre[i] : 8'(85 + i)); end
            n_checks++; if (dout1 !== exp_d1) begin n_fail++; $display("[TB] FAIL simul fwft data %0d: got %0h expected %0h", i, dout1, exp_d1); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_edge(1'b0, 1'b1, 8'd0, 1'b0);
            n_checks++; if (dout0 !== 8'(105 + i)) begin n_fail++; $display("[TB] FAIL wrap drain %0d: got %0d expected %0d", i, dout0, 105 + i); end
        end
        n_checks++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap empty: got %b/%b expected 1/1", empty0, empty1); end
    endtask

    task automatic test_fwft();
        do_edge(1'b1, 1'b0, 8'hA5, 1'b0);
        n_checks++; if (dout1 !== 8'hA5 || empty1 !== 1'b0) begin n_fail++; $display("[TB] FAIL fwft fall-through: got %0h/%b expected a5/0", dout1, empty1); end
        do_edge(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (dout1 !== 8'hA5 || empty1 !== 1'b1) begin n_fail++; $display("[TB] FAIL fwft pop hold: got %0h/%b expected a5/1", dout1, empty1); end
        do_edge(1'b1, 1'b1, 8'h5A, 1'b0);
        n_checks++; if (udf1 !== 1'b1 || cnt1 !== 5'd1 || ovf1 !== 1'b0) begin n_fail++; $display("[TB] FAIL fwft empty we+re: got udf %b cnt %0d ovf %b expected 1 1 0", udf1, cnt1, ovf1); end
        n_checks++; if (dout1 !== 8'h5A) begin n_fail++; $display("[TB] FAIL fwft empty we+re data: got %0h expected 5a", dout1); end
        do_edge(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (dout0 !== 8'h5A || empty0 !== 1'b1) begin n_fail++; $display("[TB] FAIL std read after we+re: got %0h/%b expected 5a/1", dout0, empty0); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) do_edge(1'b1, 1'b0, 8'($urandom), 1'b0);
        n_checks++; if (cnt0 !== 5'd9) begin n_fail++; $display("[TB] FAIL preload count: got %0d expected 9", cnt0); end
        do_edge(1'b1, 1'b1, 8'hEE, 1'b1);
        n_checks++; if (cnt0 !== 5'd0 || empty0 !== 1'b1 || cnt1 !== 5'd0) begin n_fail++; $display("[TB] FAIL mid reset: got cnt %0d empty %b expected 0 1", cnt0, empty0); end
        n_checks++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin n_fail++; $display("[TB] FAIL mid reset data: got %0h/%0h expected 0/0", dout0, dout1); end
        do_edge(1'b1, 1'b0, 8'h3C, 1'b0);
        n_checks++; if (dout1 !== 8'h3C || cnt0 !== 5'd1) begin n_fail++; $display("[TB] FAIL post reset write: got %0h cnt %0d expected 3c 1", dout1, cnt0); end
        do_edge(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (dout0 !== 8'h3C || empty0 !== 1'b1) begin n_fail++; $display("[TB] FAIL post reset read: got %0h/%b expected 3c/1", dout0, empty0); end
    endtask

    task automatic test_random();
        logic [5:0] ef;
        int wp;
        for (int i = 0; i < 600; i++) begin
            wp = (i < 150) ? 75 : (i < 300) ? 25 : (i < 450) ? 60 : 50;
            do_edge($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 50, 8'($urandom),
                    $urandom_range(0, 249) == 0);
            ef = {q.size() == DEPTH, q.size() == 0, q.size() >= 14, q.size() <= 2, exp_ovf, exp_udf};
            n_checks++; if (cnt0 !== CW'(q.size())) begin n_fail++; $display("[TB] FAIL random count %0d: got %0d expected %0d", i, cnt0, q.size()); end
            n_checks++; if ({full0, empty0, af0, ae0, ovf0, udf0} !== ef) begin n_fail++; $display("[TB] FAIL random flags std %0d: got %b expected %b", i, {full0, empty0, af0, ae0, ovf0, udf0}, ef); end
            n_checks++; if ({full1, empty1, af1, ae1, ovf1, udf1} !== ef || cnt1 !== CW'(q.size())) begin n_fail++; $display("[TB] FAIL random flags fwft %0d: got %b cnt %0d expected %b cnt %0d", i, {full1, empty1, af1, ae1, ovf1, udf1}, cnt1, ef, q.size()); end
            n_checks++; if (dout0 !== exp_d0) begin n_fail++; $display("[TB] FAIL random data std %0d: got %0h expected %0h", i, dout0, exp_d0); end
            n_checks++; if (dout1 !== exp_d1) begin n_fail++; $display("[TB] FAIL random data fwft %0d: got %0h expected %0h", i, dout1, exp_d1); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simul_full();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
